// File: rtl/act_lut_loader.sv
// Programmable activation lookup table: a config stream loads every entry, then
// input codes are looked up with valid/ready handshaking and one cycle of latency.
//
// state | meaning
// LOAD  | accepting table entries on the cfg stream; lookups blocked
// RUN   | table complete; lookups enabled, cfg stream ignored
module act_lut_loader #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_OUT_0_PRECISION_0 = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_start,
    input  logic [DATA_OUT_0_PRECISION_0-1:0] cfg_data,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    output logic                              cfg_loaded,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int IN_W  = DATA_IN_0_PRECISION_0;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int DEPTH = 1 << IN_W;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      state;
    logic [IN_W-1:0] addr;
    logic [OUT_W-1:0] lut [DEPTH];

    logic cfg_accept;
    logic lkp_accept;
    logic last_beat;

    assign cfg_ready  = (state == ST_LOAD) && !cfg_start;
    assign cfg_accept = cfg_valid && cfg_ready;
    assign last_beat  = (addr == {IN_W{1'b1}});
    assign cfg_loaded = (state == ST_RUN);

    // A restart request blocks new lookups in the same cycle it is seen.
    assign data_in_0_ready = (state == ST_RUN) && !cfg_start &&
                             (!data_out_0_valid || data_out_0_ready);
    assign lkp_accept = data_in_0_valid && data_in_0_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
            addr  <= '0;
        end else if (cfg_start) begin
            state <= ST_LOAD;
            addr  <= '0;
        end else if (cfg_accept) begin
            addr <= addr + 1'b1;
            if (last_beat) begin
                state <= ST_RUN;
            end
        end
    end

    // Table storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (cfg_accept) begin
            lut[addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_0       <= '0;
            data_out_0_valid <= 1'b0;
        end else if (lkp_accept) begin
            data_out_0       <= lut[data_in_0];
            data_out_0_valid <= 1'b1;
        end else if (data_out_0_valid && data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: the driver queues hand-computed lookup
// results, a negedge monitor pops and compares them on each output handshake.
module tb_act_lut_loader;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_loaded;
    logic [7:0] data_in_0;
    logic       data_in_0_valid;
    logic       data_in_0_ready;
    logic [7:0] data_out_0;
    logic       data_out_0_valid;
    logic       data_out_0_ready;

    typedef struct {
        logic [7:0] d;
        int         ec;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    act_lut_loader #(
        .DATA_IN_0_PRECISION_0 (8),
        .DATA_OUT_0_PRECISION_0(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_data        (cfg_data),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_loaded      (cfg_loaded),
        .data_in_0       (data_in_0),
        .data_in_0_valid (data_in_0_valid),
        .data_in_0_ready (data_in_0_ready),
        .data_out_0      (data_out_0),
        .data_out_0_valid(data_out_0_valid),
        .data_out_0_ready(data_out_0_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic cfg_beat(input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        @(negedge clk);
        chk1("cfg_ready_load", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'hEE;
        @(negedge clk);
        chk1("cfg_ready_during_start", cfg_ready, 1'b0);
        chk1("din_ready_during_start", data_in_0_ready, 1'b0);
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] code, input logic [7:0] exp, input bit timed);
        bit   got;
        exp_t e;
        got             = 1'b0;
        data_in_0       = code;
        data_in_0_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (data_in_0_ready) begin
                e.d  = exp;
                e.ec = timed ? cyc + 1 : -1;
                sb.push_back(e);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        data_in_0_valid = 1'b0;
        chk1("lookup_accepted", got, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && data_out_0_valid && data_out_0_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h with no pending lookup (cycle %0d)",
                             data_out_0, cyc);
                end else begin
                    e = sb.pop_front();
                    chk8("lookup_data", data_out_0, e.d);
                    if (e.ec >= 0) chki("lookup_latency", cyc, e.ec);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] v;
        rst              = 1'b0;
        cfg_start        = 1'b0;
        cfg_data         = 8'h00;
        cfg_valid        = 1'b0;
        data_in_0        = 8'h00;
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk1("rst_cfg_loaded", cfg_loaded, 1'b0);
        chk1("rst_dout_valid", data_out_0_valid, 1'b0);
        chk8("rst_dout", data_out_0, 8'h00);
        chk1("rst_cfg_ready", cfg_ready, 1'b1);
        chk1("rst_din_ready", data_in_0_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: full load with entry[i] = i ^ A5
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk1("loaded_before_last", cfg_loaded, 1'b0);
            v = 8'(i) ^ 8'hA5;
            cfg_beat(v);
        end
        cfg_valid = 1'b1;
        @(negedge clk);
        chk1("loaded_after_last", cfg_loaded, 1'b1);
        chk1("cfg_ready_in_run", cfg_ready, 1'b0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;

        // 2: back-to-back lookups
        lookup(8'h00, 8'hA5, 1'b1);
        lookup(8'hFF, 8'h5A, 1'b1);
        lookup(8'h3C, 8'h99, 1'b1);
        idle(3);

        // 3: backpressure holds output
        data_out_0_ready = 1'b0;
        lookup(8'h10, 8'hB5, 1'b0);
        data_in_0       = 8'h20;
        data_in_0_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk8("hold_dout", data_out_0, 8'hB5);
            chk1("hold_valid", data_out_0_valid, 1'b1);
            chk1("hold_din_ready", data_in_0_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        idle(3);

        // 4: lookups blocked in LOAD
        pulse_start();
        data_in_0       = 8'h10;
        data_in_0_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk1("load_din_ready", data_in_0_ready, 1'b0);
            chk1("load_cfg_loaded", cfg_loaded, 1'b0);
            chk1("load_dout_valid", data_out_0_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        data_in_0_valid = 1'b0;

        // 5: restart at addr 100, then load entry[i] = i
        for (int i = 0; i < 100; i++) begin
            v = 8'(i) ^ 8'hA5;
            cfg_beat(v);
        end
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            cfg_beat(v);
        end
        @(negedge clk);
        chk1("reload_loaded", cfg_loaded, 1'b1);
        @(posedge clk);
        #1;
        lookup(8'h64, 8'h64, 1'b1);
        lookup(8'hC8, 8'hC8, 1'b1);
        idle(3);

        // 6a: reset mid-load at addr 200
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            v = 8'(i) ^ 8'h5A;
            cfg_beat(v);
        end
        rst = 1'b0;
        @(negedge clk);
        chk1("midload_rst_loaded", cfg_loaded, 1'b0);
        chk1("midload_rst_valid", data_out_0_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = ~8'(i);
            cfg_beat(v);
        end
        lookup(8'h00, 8'hFF, 1'b1);
        lookup(8'hC8, 8'h37, 1'b1);
        idle(3);

        // 6b: reset mid-stream with an output pending
        data_out_0_ready = 1'b0;
        lookup(8'h01, 8'hFE, 1'b0);
        @(negedge clk);
        chk1("pending_valid", data_out_0_valid, 1'b1);
        chk8("pending_dout", data_out_0, 8'hFE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk8("midrun_rst_dout", data_out_0, 8'h00);
        chk1("midrun_rst_valid", data_out_0_valid, 1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        rst              = 1'b1;
        data_out_0_ready = 1'b1;
        idle(3);
        @(negedge clk);
        chk1("post_rst_loaded", cfg_loaded, 1'b0);
        chk1("post_rst_valid", data_out_0_valid, 1'b0);
        chki("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
